// File: rtl/dbg_pkg.sv
// Shared debug-block definitions: register-file geometry and the dump FSM encoding.
package dbg_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks a wrapping index range over the combinational
// read port and streams each value out on a valid/ready interface.
module regfile_dump
    import dbg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_AW-1:0] first_idx,
    input  logic [REG_AW-1:0] last_idx,
    input  logic              abort,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [REG_AW-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       state, state_next;
    logic [REG_AW-1:0] idx, last_q, idx_inc, cap_idx;
    logic              load_range, capture, clear, finish, hs;

    // 5-bit overflow gives the 31 -> 0 wrap for free.
    assign idx_inc = idx + 1'b1;
    assign hs      = out_valid && out_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_addr    = '0;
        cap_idx    = idx;
        load_range = 1'b0;
        capture    = 1'b0;
        clear      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load_range = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                rd_addr = idx;
                if (abort) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end else begin
                    capture    = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                // Prefetch address for the next word so it can be captured on the handshake.
                rd_addr = idx_inc;
                cap_idx = idx_inc;
                if (abort) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end else if (hs) begin
                    if (out_last) begin
                        clear      = 1'b1;
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (load_range) begin
                idx    <= first_idx;
                last_q <= last_idx;
            end
            if (capture) begin
                idx       <= cap_idx;
                out_idx   <= cap_idx;
                // x0 storage may hold junk; the architectural value is always zero.
                out_data  <= (cap_idx == '0) ? '0 : rd_data;
                out_last  <= (cap_idx == last_q);
                out_valid <= 1'b1;
            end
            if (clear) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: vector table of ranges plus hand-written abort/reset sequences.
module tb_regfile_dump;
    import dbg_pkg::*;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst, start, abort, out_ready;
    logic [REG_AW-1:0] first_idx, last_idx, rd_addr, out_idx;
    logic [WIDTH-1:0]  rd_data, out_data;
    logic              out_valid, out_last, busy, done;

    logic [WIDTH-1:0]  regs [REG_COUNT];
    assign rd_data = regs[rd_addr];

    regfile_dump #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [REG_AW-1:0] idx;
        logic [WIDTH-1:0]  data;
        logic              last;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [REG_AW-1:0] first;
        logic [REG_AW-1:0] last;
        int                nwords;
        int                done_rel;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_data(input logic [REG_AW-1:0] i);
        return (i == 0) ? 32'h0 : (32'h1000_0000 + {27'd0, i});
    endfunction

    task automatic push_range(input logic [REG_AW-1:0] f, input logic [REG_AW-1:0] l);
        logic [REG_AW-1:0] d, i;
        int n;
        exp_t e;
        d = l - f;
        n = int'(d) + 1;
        for (int k = 0; k < n; k++) begin
            i = f + k[REG_AW-1:0];
            e.idx  = i;
            e.data = exp_data(i);
            e.last = (k == n - 1);
            sbq.push_back(e);
        end
    endtask

    // Scoreboard monitor and stall-stability checker.
    logic              stall_p = 1'b0, abort_p = 1'b0;
    logic [REG_AW-1:0] idx_p;
    logic [WIDTH-1:0]  data_p;
    logic              last_p;

    always @(negedge clk) begin
        if (rst) begin
            stall_p <= 1'b0;
        end else begin
            if (done) check("busy_with_done", {31'd0, busy}, 32'd0);
            if (stall_p && !abort_p) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_idx",   {27'd0, out_idx},   {27'd0, idx_p});
                check("stall_data",  out_data,           data_p);
                check("stall_last",  {31'd0, out_last},  {31'd0, last_p});
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got idx %0d, no word expected", out_idx);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("word_idx",  {27'd0, out_idx},  {27'd0, e.idx});
                    check("word_data", out_data,          e.data);
                    check("word_last", {31'd0, out_last}, {31'd0, e.last});
                end
                pops <= pops + 1;
            end
            stall_p <= out_valid && !out_ready;
            abort_p <= abort;
            idx_p   <= out_idx;
            data_p  <= out_data;
            last_p  <= out_last;
        end
    end

    // mode 0: ready held high; mode 1: random ready with an ignored start mid-dump.
    task automatic run_dump(input logic [REG_AW-1:0] f, input logic [REG_AW-1:0] l,
                            input int mode, input int exp_n, input bit timing,
                            output int rel_done);
        int t0, p0, rel;
        push_range(f, l);
        p0 = pops;
        @(posedge clk); #1;
        start = 1'b1; first_idx = f; last_idx = l;
        out_ready = 1'b1;
        t0 = cyc;
        rel_done = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            if (mode == 1 && k == 10) begin
                start = 1'b1; first_idx = 5'd7; last_idx = 5'd8;
            end
            rel = cyc - t0;
            if (timing && rel == 1) begin
                check("busy_rise",   {31'd0, busy},      32'd1);
                check("load_novalid", {31'd0, out_valid}, 32'd0);
            end
            if (timing && rel == 2) check("first_valid", {31'd0, out_valid}, 32'd1);
            if (done) begin
                rel_done = rel;
                break;
            end
            if (mode == 1) check("busy_held", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        if (rel_done < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 400 cycles, first %0d last %0d", f, l);
        end
        check("word_count", pops - p0, exp_n);
        check("queue_empty", sbq.size(), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        sbq.delete();
    endtask

    vec_t vecs[5];

    initial begin
        int rel;

        vecs[0] = '{5'd0,  5'd31, 32, 34};
        vecs[1] = '{5'd30, 5'd1,  4,  6};
        vecs[2] = '{5'd10, 5'd10, 1,  3};
        vecs[3] = '{5'd5,  5'd4,  32, 34};
        vecs[4] = '{5'd31, 5'd0,  2,  4};

        for (int i = 0; i < REG_COUNT; i++) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'hDEAD_BEEF;

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        first_idx = '0; last_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_data",  out_data,           32'd0);
        check("rst_idx",   {27'd0, out_idx},   32'd0);
        check("rst_addr",  {27'd0, rd_addr},   32'd0);
        rst = 1'b0;

        // abort beats start in IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; first_idx = 5'd3; last_idx = 5'd4;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("abort_start_valid", {31'd0, out_valid}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_dump(vecs[v].first, vecs[v].last, 0, vecs[v].nwords, 1'b1, rel);
            check("done_cycle", rel, vecs[v].done_rel);
        end

        run_dump(5'd0, 5'd31, 1, 32, 1'b0, rel);

        // abort during a stall at idx 5, with an ignored start mid-dump
        begin
            exp_t e;
            for (int i = 0; i < 5; i++) begin
                e.idx = i[REG_AW-1:0]; e.data = exp_data(i[REG_AW-1:0]); e.last = 1'b0;
                sbq.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31; out_ready = 1'b1;
        rel = -1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid && out_idx == 5'd5) begin
                out_ready = 1'b0;
                rel = k;
                break;
            end
        end
        if (rel < 0) begin
            tests++;
            fails++;
            $display("FAIL abort_reach_idx5: idx 5 never presented");
        end
        @(posedge clk); #1;
        start = 1'b1; first_idx = 5'd20; last_idx = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        check("stall_start_ignored", {27'd0, out_idx}, 32'd5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy",  {31'd0, busy},      32'd0);
        check("abort_done",  {31'd0, done},      32'd0);
        @(posedge clk); #1;
        check("abort_done2", {31'd0, done},      32'd0);
        check("abort_queue", sbq.size(),         32'd0);
        out_ready = 1'b1;
        run_dump(5'd3, 5'd6, 0, 4, 1'b1, rel);
        check("post_abort_done_cycle", rel, 32'd6);

        // asynchronous reset mid-dump
        push_range(5'd0, 5'd31);
        @(posedge clk); #1;
        start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_last",  {31'd0, out_last},  32'd0);
        check("arst_busy",  {31'd0, busy},      32'd0);
        check("arst_done",  {31'd0, done},      32'd0);
        check("arst_data",  out_data,           32'd0);
        check("arst_idx",   {27'd0, out_idx},   32'd0);
        check("arst_addr",  {27'd0, rd_addr},   32'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy",  {31'd0, busy},      32'd0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        run_dump(5'd30, 5'd1, 0, 4, 1'b1, rel);
        check("post_rst_done_cycle", rel, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
